// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rng_pkg
//  Purpose  : Shared constants, types and helper functions for the
//             multi-channel Galois-LFSR random generator.
//  Contents : LFSR tap constants, lfsr_taps(), derive_seed(), pow2_mask(),
//             per-channel state enum.
//  Revision : 1.0  initial release
// ============================================================================
package rng_pkg;

    // Right-shift Galois tap masks for the supported widths
    localparam logic [31:0] c_taps_w8  = 32'h0000_00B8;
    localparam logic [31:0] c_taps_w16 = 32'h0000_B400;
    localparam logic [31:0] c_taps_w32 = 32'h8020_0003;

    // Golden-ratio multiplier used to spread channel seeds apart
    localparam logic [31:0] c_seed_mult = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } rng_state_e;

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return c_taps_w8;
            16:      return c_taps_w16;
            default: return c_taps_w32;
        endcase
    endfunction

    // Seed depends only on the root seed and the channel's own index, so
    // changing the channel count never disturbs existing channels.
    function automatic logic [31:0] derive_seed(input logic [31:0] base,
                                                input int unsigned idx);
        return base ^ (32'(idx) * c_seed_mult);
    endfunction

    // Smallest 2^k-1 that is >= lim: smear the top set bit downwards.
    function automatic logic [31:0] pow2_mask(input logic [31:0] lim);
        logic [31:0] m;
        m = lim;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage : rng_pkg
`default_nettype wire

// File: rtl/rng_channel.sv
`default_nettype none
// ============================================================================
//  Module   : rng_channel
//  Purpose  : One independent random channel: Galois LFSR plus an
//             IDLE/DRAW/HOLD handshake FSM doing mask-and-reject sampling
//             into [0, limit], with clamp fallback after MAX_RETRY misses.
//  Ports    : clk, rst_n (async active-low)
//             req_valid_i/req_ready_o/req_limit_i   request side
//             rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_clamp_o  response side
//             seed_we_i/seed_val_i                  reseed (any state)
//  Revision : 1.0  initial release
// ============================================================================
module rng_channel
    import rng_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               MAX_RETRY = 8,
    parameter logic [WIDTH-1:0] INIT_SEED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_limit_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_clamp_o,
    input  logic             seed_we_i,
    input  logic [WIDTH-1:0] seed_val_i
);

    localparam int               RW           = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [WIDTH-1:0] c_taps       = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [RW-1:0]    c_retry_last = RW'(MAX_RETRY - 1);

    rng_state_e       state_q, state_d;
    logic [WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [WIDTH-1:0] lim_q,   lim_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             clamp_q, clamp_d;

    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] seed_fix;

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? c_taps : '0);
    assign cand      = lfsr_step & mask_q;
    // An all-zero state would lock the LFSR forever
    assign seed_fix  = (seed_val_i == '0) ? WIDTH'(1) : seed_val_i;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        lim_d   = lim_q;
        mask_d  = mask_q;
        retry_d = retry_q;
        data_d  = data_q;
        clamp_d = clamp_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    lim_d   = req_limit_i;
                    mask_d  = WIDTH'(pow2_mask(32'(req_limit_i)));
                    retry_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                // A reseed this cycle replaces the step; the candidate is
                // then taken from the loaded value on the following cycle.
                if (!seed_we_i) begin
                    lfsr_d = lfsr_step;
                    if (cand <= lim_q) begin
                        data_d  = cand;
                        clamp_d = 1'b0;
                        state_d = HOLD;
                    end else if (retry_q == c_retry_last) begin
                        data_d  = lim_q;
                        clamp_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        retry_d = retry_q + RW'(1);
                    end
                end
            end
            HOLD: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (seed_we_i) begin
            lfsr_d = seed_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= INIT_SEED;
            lim_q   <= '0;
            mask_q  <= '0;
            retry_q <= '0;
            data_q  <= '0;
            clamp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            lim_q   <= lim_d;
            mask_q  <= mask_d;
            retry_q <= retry_d;
            data_q  <= data_d;
            clamp_q <= clamp_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == HOLD);
    assign rsp_data_o  = data_q;
    assign rsp_clamp_o = clamp_q;

endmodule : rng_channel
`default_nettype wire

// File: rtl/rng_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : rng_multi_channel
//  Purpose  : NUM_CH independent random channels, each with its own derived
//             seed and req/rsp handshake. Only slices buses and decodes the
//             reseed strobe; all behaviour lives in rng_channel.
//  Ports    : clk, rst_n (async active-low)
//             req_valid/req_ready/req_limit[NUM_CH*WIDTH]
//             rsp_valid/rsp_ready/rsp_data[NUM_CH*WIDTH]/rsp_clamp
//             seed_we/seed_ch/seed_val  (seed_ch >= NUM_CH ignored)
//  Revision : 1.0  initial release
// ============================================================================
module rng_multi_channel
    import rng_pkg::*;
#(
    parameter int          NUM_CH    = 3,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_SEED = 32'h0000_0001,
    parameter int          MAX_RETRY = 8,
    localparam int         SCW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH*WIDTH-1:0] req_limit,
    output logic [NUM_CH-1:0]       rsp_valid,
    input  logic [NUM_CH-1:0]       rsp_ready,
    output logic [NUM_CH*WIDTH-1:0] rsp_data,
    output logic [NUM_CH-1:0]       rsp_clamp,
    input  logic                    seed_we,
    input  logic [SCW-1:0]          seed_ch,
    input  logic [WIDTH-1:0]        seed_val
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [31:0]      c_raw  = derive_seed(BASE_SEED, i);
        localparam logic [WIDTH-1:0] c_seed = (WIDTH'(c_raw) == '0) ? WIDTH'(1) : WIDTH'(c_raw);

        logic seed_hit;
        assign seed_hit = seed_we && (seed_ch == SCW'(i));

        rng_channel #(
            .WIDTH     (WIDTH),
            .MAX_RETRY (MAX_RETRY),
            .INIT_SEED (c_seed)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid_i (req_valid[i]),
            .req_ready_o (req_ready[i]),
            .req_limit_i (req_limit[i*WIDTH +: WIDTH]),
            .rsp_valid_o (rsp_valid[i]),
            .rsp_ready_i (rsp_ready[i]),
            .rsp_data_o  (rsp_data[i*WIDTH +: WIDTH]),
            .rsp_clamp_o (rsp_clamp[i]),
            .seed_we_i   (seed_hit),
            .seed_val_i  (seed_val)
        );
    end : g_ch

endmodule : rng_multi_channel
`default_nettype wire
